// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control slice: FSM state encoding and
// the {wr_en, rd_en} op-codes sampled every clock.
package fifo_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101,
    WR_RD    = 3'b110
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_BOTH  = 2'b11;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the FIFO user and fifo_ctrl.
// FIFO_ALMOST_FLAGS_EN adds the almost_full / almost_empty status lines.
interface fifo_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  // Handshake: wr_en/rd_en are sampled at each posedge; the matching
  // ack (accepted) or err (rejected) pulses for exactly one cycle after.
  logic             wr_en;
  logic             rd_en;
  logic [DEPTH-1:0] wr_row_en;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             wr_ack;
  logic             wr_err;
  logic             rd_ack;
  logic             rd_err;
  logic [AW:0]      data_count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic             almost_full;
  logic             almost_empty;
`endif

  modport master (
`ifdef FIFO_ALMOST_FLAGS_EN
    input  almost_full, almost_empty,
`endif
    output wr_en, rd_en,
    input  wr_row_en, rd_ptr, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err, data_count
  );

  modport slave (
`ifdef FIFO_ALMOST_FLAGS_EN
    output almost_full, almost_empty,
`endif
    input  wr_en, rd_en,
    output wr_row_en, rd_ptr, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err, data_count
  );

endinterface

// File: rtl/fifo_cal_addr.sv
// Next-state arithmetic for the FIFO pointers and occupancy, plus the
// one-hot row write-enable decode. Purely combinational.
module fifo_cal_addr #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             full,
  input  logic             empty,
  input  logic [AW-1:0]    wr_ptr,
  input  logic [AW-1:0]    rd_ptr,
  input  logic [AW:0]      data_count,
  output logic             wr_accept,
  output logic             rd_accept,
  output logic [AW-1:0]    wr_ptr_nxt,
  output logic [AW-1:0]    rd_ptr_nxt,
  output logic [AW:0]      count_nxt,
  output logic [DEPTH-1:0] wr_row_en
);

  always_comb begin
    wr_accept  = !reset && wr_en && !full;
    rd_accept  = !reset && rd_en && !empty;
    // DEPTH is a power of two, so the AW-bit add wraps DEPTH-1 -> 0.
    wr_ptr_nxt = wr_accept ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_nxt = rd_accept ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = data_count;
    if (wr_accept && !rd_accept)
      count_nxt = data_count + (AW+1)'(1);
    else if (rd_accept && !wr_accept)
      count_nxt = data_count - (AW+1)'(1);
    wr_row_en = '0;
    if (wr_accept)
      wr_row_en[wr_ptr] = 1'b1;
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: pointer/count registers and the op-recording FSM.
// FIFO_ALMOST_FLAGS_EN enables registered almost_full / almost_empty.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  fifo_ctrl_if.slave   bus,
  output state_t       state
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]   data_count, count_nxt;
  logic          full, empty;
  logic          wr_accept, rd_accept;
  logic          wr_ack, wr_err, rd_ack, rd_err;

  fifo_cal_addr #(.DEPTH(DEPTH), .AW(AW)) u_cal_addr (
    .reset      (reset),
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .full       (full),
    .empty      (empty),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .data_count (data_count),
    .wr_accept  (wr_accept),
    .rd_accept  (rd_accept),
    .wr_ptr_nxt (wr_ptr_nxt),
    .rd_ptr_nxt (rd_ptr_nxt),
    .count_nxt  (count_nxt),
    .wr_row_en  (bus.wr_row_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      data_count <= count_nxt;
      full       <= (count_nxt == DEPTH_C);
      empty      <= (count_nxt == '0);
      wr_ack     <= wr_accept;
      wr_err     <= bus.wr_en && !wr_accept;
      rd_ack     <= rd_accept;
      rd_err     <= bus.rd_en && !rd_accept;
      case ({bus.wr_en, bus.rd_en})
        OP_NONE:  state <= NO_OP;
        OP_WRITE: state <= wr_accept ? WRITE : WR_ERROR;
        OP_READ:  state <= rd_accept ? READ : RD_ERROR;
        OP_BOTH: begin
          // At a boundary only one side can proceed; the state names it.
          if (wr_accept && rd_accept) state <= WR_RD;
          else if (wr_accept)         state <= WRITE;
          else                        state <= READ;
        end
        default:  state <= NO_OP;
      endcase
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  logic almost_full, almost_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b0;
    end else begin
      almost_full  <= (count_nxt == DEPTH_C - (AW+1)'(1));
      almost_empty <= (count_nxt == (AW+1)'(1));
    end
  end

  assign bus.almost_full  = almost_full;
  assign bus.almost_empty = almost_empty;
`endif

  assign bus.rd_ptr     = rd_ptr;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.data_count = data_count;
  assign bus.wr_ack     = wr_ack;
  assign bus.wr_err     = wr_err;
  assign bus.rd_ack     = rd_ack;
  assign bus.rd_err     = rd_err;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a reference occupancy/pointer model,
// a register-row model fed by wr_row_en, and a data scoreboard queue.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic   clk = 1'b0;
  logic   reset;
  state_t state;

  fifo_ctrl_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] row_mem [DEPTH];
  logic [7:0] exp_q [$];
  logic [7:0] wr_data;

  int m_count;
  int m_wp;
  int m_rp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input state_t es,
                              input bit ewa, input bit ewe, input bit era, input bit ere);
    check({tag, "_count"},  32'(bus.data_count), 32'(m_count));
    check({tag, "_full"},   32'(bus.full),       32'(m_count == DEPTH));
    check({tag, "_empty"},  32'(bus.empty),      32'(m_count == 0));
    check({tag, "_rd_ptr"}, 32'(bus.rd_ptr),     32'(m_rp));
    check({tag, "_wr_ack"}, 32'(bus.wr_ack),     32'(ewa));
    check({tag, "_wr_err"}, 32'(bus.wr_err),     32'(ewe));
    check({tag, "_rd_ack"}, 32'(bus.rd_ack),     32'(era));
    check({tag, "_rd_err"}, 32'(bus.rd_err),     32'(ere));
    check({tag, "_state"},  32'(state),          32'(es));
`ifdef FIFO_ALMOST_FLAGS_EN
    check({tag, "_almost_full"},  32'(bus.almost_full),  32'(m_count == DEPTH - 1));
    check({tag, "_almost_empty"}, 32'(bus.almost_empty), 32'(m_count == 1));
`endif
  endtask

  // Driver: reset for n edges with wr_en held high; requests must be ignored.
  task automatic apply_reset(input int n);
    reset     = 1'b1;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b0;
    #1;
    check("rst_row_en", 32'(bus.wr_row_en), 32'(0));
    repeat (n) @(posedge clk);
    @(negedge clk);
    m_count = 0;
    m_wp    = 0;
    m_rp    = 0;
    exp_q.delete();
    check_status("rst", INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.wr_en = 1'b0;
    reset     = 1'b0;
  endtask

  // Driver: one request cycle, launched just after a negedge.
  task automatic do_op(input bit w, input bit r);
    bit               wa, ra;
    state_t           es;
    logic [7:0]       d;
    logic [DEPTH-1:0] row_en_s;
    bus.wr_en = w;
    bus.rd_en = r;
    wr_data   = 8'($urandom_range(0, 255));
    wa = w && (m_count < DEPTH);
    ra = r && (m_count > 0);
    #1;
    row_en_s = bus.wr_row_en;
    check("wr_row_en", 32'(row_en_s), wa ? (32'(1) << m_wp) : 32'(0));
    if (ra) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(1), 32'(0));
      end else begin
        d = exp_q.pop_front();
        check("rd_data", 32'(row_mem[bus.rd_ptr]), 32'(d));
      end
    end
    if (wa) exp_q.push_back(wr_data);
    if (wa && ra)  es = WR_RD;
    else if (wa)   es = WRITE;
    else if (ra)   es = READ;
    else if (w)    es = WR_ERROR;
    else if (r)    es = RD_ERROR;
    else           es = NO_OP;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++)
      if (row_en_s[i]) row_mem[i] = wr_data;
    m_count = m_count + int'(wa) - int'(ra);
    if (wa) m_wp = (m_wp + 1) % DEPTH;
    if (ra) m_rp = (m_rp + 1) % DEPTH;
    @(negedge clk);
    check_status("op", es, wa, w && !wa, ra, r && !ra);
  endtask

  initial begin
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    wr_data   = '0;

    apply_reset(2);

    // Fill, then overflow attempt
    repeat (8) do_op(1'b1, 1'b0);
    check("fill_full", 32'(bus.full), 32'(1));
    do_op(1'b1, 1'b0);
    check("ovf_count", 32'(bus.data_count), 32'(8));

    // Drain with pointer wrap, then underflow attempt
    repeat (8) do_op(1'b0, 1'b1);
    check("drain_wrap", 32'(bus.rd_ptr), 32'(0));
    do_op(1'b0, 1'b1);
    check("udf_rd_ptr", 32'(bus.rd_ptr), 32'(0));

    // Concurrent read/write at count 3
    repeat (3) do_op(1'b1, 1'b0);
    repeat (4) do_op(1'b1, 1'b1);
    check("wrrd_count", 32'(bus.data_count), 32'(3));

    // Concurrent requests at both boundaries
    repeat (3) do_op(1'b0, 1'b1);
    do_op(1'b1, 1'b1);
    check("both_empty_count", 32'(bus.data_count), 32'(1));
    repeat (7) do_op(1'b1, 1'b0);
    do_op(1'b1, 1'b1);
    check("both_full_count", 32'(bus.data_count), 32'(7));

    // Reset mid-stream at count 5
    repeat (2) do_op(1'b0, 1'b1);
    check("pre_rst_count", 32'(bus.data_count), 32'(5));
    apply_reset(1);

    // Random traffic, with an occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) apply_reset(1);
      else do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
